uart_tx: RTL and testbench

Serial UART transmitter feeding the team's single-sample-per-clock UART receiver. It accepts parallel bytes over a valid/ready handshake and serializes each one as one bit per clk cycle. Frame order: start bit (0), data LSB-first, odd parity bit, stop bit (1). It is the upstream stage of the receive path and is used in loopback with the receiver. Idle line level is high.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx.sv | 119 +++++++++++
 tb/tb_uart_tx.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line-level constants and the parity
// helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Zero-extension does not change the XOR reduction, so one width serves all callers.
    function automatic logic odd_parity(input logic [31:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one serial bit per clk, frame = start, data LSB-first,
// odd parity, stop, followed by an optional forced idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    uart_state_t           state_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt_reg;
    logic [GW-1:0]         gap_cnt_reg;
    logic                  parity_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  tx_done_reg;
    logic                  ready;
    logic                  transfer;

    // Ready is the only combinational output; it must drop while reset is held.
    always_comb begin
        ready = 1'b0;
        case (state_reg)
            IDLE:    ready = 1'b1;
            STOP:    ready = (GAP_CYCLES == 0);
            GAP:     ready = (gap_cnt_reg == LAST_GAP);
            default: ready = 1'b0;
        endcase
        if (reset) begin
            ready = 1'b0;
        end
    end

    assign transfer = in_valid && ready;

    // tx, busy and tx_done are registered together with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= IDLE_LEVEL;
            busy_reg    <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                START: begin
                    state_reg   <= DATA;
                    tx_reg      <= shift_reg[0];
                    shift_reg   <= shift_reg >> 1;
                    bit_cnt_reg <= '0;
                end
                DATA: begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_reg <= PARITY;
                        tx_reg    <= parity_reg;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + CW'(1);
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                    end
                end
                PARITY: begin
                    state_reg   <= STOP;
                    tx_reg      <= STOP_BIT;
                    tx_done_reg <= 1'b1;
                end
                STOP, GAP, IDLE: begin
                    if (transfer) begin
                        state_reg  <= START;
                        tx_reg     <= START_BIT;
                        busy_reg   <= 1'b1;
                        shift_reg  <= in_byte;
                        parity_reg <= odd_parity(32'(in_byte));
                    end else if (state_reg == STOP && GAP_CYCLES > 0) begin
                        state_reg   <= GAP;
                        tx_reg      <= IDLE_LEVEL;
                        gap_cnt_reg <= '0;
                    end else if (state_reg == GAP && gap_cnt_reg != LAST_GAP) begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end else begin
                        state_reg <= IDLE;
                        tx_reg    <= IDLE_LEVEL;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= IDLE_LEVEL;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = ready;
    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with no gap, one with a 2-cycle gap
// whose line is decoded by a small behavioural receiver.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, busy, tx_done;
    logic [7:0] g_in_byte = 8'h00;
    logic       g_in_valid = 1'b0;
    logic       g_in_ready, g_tx, g_busy, g_tx_done;

    logic s_tx, s_ready, s_busy, s_done;
    logic sg_tx, sg_ready, sg_busy, sg_done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx #(.DATA_WIDTH(8), .GAP_CYCLES(2)) dut_gap (
        .clk(clk), .reset(reset), .in_byte(g_in_byte), .in_valid(g_in_valid),
        .in_ready(g_in_ready), .tx(g_tx), .busy(g_busy), .tx_done(g_tx_done)
    );

    // Advance to the next falling edge and snapshot every DUT output there.
    task automatic step();
        @(negedge clk);
        s_tx = tx;     s_ready = in_ready;   s_busy = busy;   s_done = tx_done;
        sg_tx = g_tx;  sg_ready = g_in_ready; sg_busy = g_busy; sg_done = g_tx_done;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_byte = 8'hFF;
        step(); step();
        tests_run++;
        if ({s_tx, s_busy, s_done, s_ready} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got tx/busy/done/ready=%b expected 1000", {s_tx, s_busy, s_done, s_ready});
        end
        tests_run++;
        if ({sg_tx, sg_busy, sg_done, sg_ready} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_outputs_gap: got %b expected 1000", {sg_tx, sg_busy, sg_done, sg_ready});
        end
        reset = 1'b0; in_valid = 1'b0;
        step();
        tests_run++;
        if ({s_tx, s_busy, s_done, s_ready} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got tx/busy/done/ready=%b expected 1001", {s_tx, s_busy, s_done, s_ready});
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_frame();
        logic [10:0] got_tx, got_ready, got_done;
        logic        all_busy;
        all_busy = 1'b1;
        in_valid = 1'b1; in_byte = 8'hA5;
        for (int i = 0; i < 11; i++) begin
            step();
            got_tx[10-i] = s_tx; got_ready[10-i] = s_ready; got_done[10-i] = s_done;
            all_busy = all_busy & s_busy;
            if (i == 0) begin
                in_valid = 1'b0; in_byte = 8'h00;
            end
        end
        tests_run++;
        if (got_tx !== 11'b01010010111) begin
            tests_failed++;
            $display("FAIL frame_a5_tx: got %b expected 01010010111", got_tx);
        end
        tests_run++;
        if (got_ready !== 11'b00000000001) begin
            tests_failed++;
            $display("FAIL frame_a5_ready: got %b expected 00000000001", got_ready);
        end
        tests_run++;
        if (got_done !== 11'b00000000001 || all_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_a5_done_busy: got done=%b busy_all=%b expected 00000000001/1", got_done, all_busy);
        end
        step();
        tests_run++;
        if ({s_tx, s_busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL frame_a5_return_idle: got tx/busy=%b expected 10", {s_tx, s_busy});
        end
        $display("[TB] frame 0xa5 tx=%b", got_tx);
    endtask

    task automatic test_back_to_back();
        logic [21:0] got_tx, got_done;
        logic        all_busy;
        all_busy = 1'b1;
        in_valid = 1'b1; in_byte = 8'h00;
        for (int i = 0; i < 22; i++) begin
            step();
            got_tx[21-i] = s_tx; got_done[21-i] = s_done;
            all_busy = all_busy & s_busy;
            if (i == 0) in_byte = 8'hFF;
            if (i == 11) in_valid = 1'b0;
        end
        tests_run++;
        if (got_tx !== {11'b00000000011, 11'b01111111111}) begin
            tests_failed++;
            $display("FAIL b2b_stream: got %b expected 0000000001101111111111", got_tx);
        end
        tests_run++;
        if (got_done !== 22'b0000000000100000000001 || all_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done_busy: got done=%b busy_all=%b expected 0000000000100000000001/1", got_done, all_busy);
        end
        step();
        tests_run++;
        if ({s_tx, s_busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_return_idle: got tx/busy=%b expected 10", {s_tx, s_busy});
        end
        $display("[TB] back-to-back 0x00,0xff tx=%b", got_tx);
    endtask

    task automatic test_parity();
        logic [7:0]  vals [3]     = '{8'h01, 8'h03, 8'h80};
        logic [10:0] frames [3]   = '{11'b01000000001, 11'b01100000011, 11'b00000000101};
        logic        parities [3] = '{1'b0, 1'b1, 1'b0};
        logic [10:0] got_tx;
        for (int v = 0; v < 3; v++) begin
            in_valid = 1'b1; in_byte = vals[v];
            for (int i = 0; i < 11; i++) begin
                step();
                got_tx[10-i] = s_tx;
                if (i == 0) in_valid = 1'b0;
            end
            tests_run++;
            if (got_tx[1] !== parities[v]) begin
                tests_failed++;
                $display("FAIL parity_bit_%h: got %b expected %b", vals[v], got_tx[1], parities[v]);
            end
            tests_run++;
            if (got_tx !== frames[v]) begin
                tests_failed++;
                $display("FAIL parity_frame_%h: got %b expected %b", vals[v], got_tx, frames[v]);
            end
            step();
            $display("[TB] parity frame 0x%h tx=%b", vals[v], got_tx);
        end
    endtask

    task automatic test_stall();
        logic [21:0] got_tx, got_done;
        in_valid = 1'b1; in_byte = 8'h0F;
        for (int i = 0; i < 22; i++) begin
            step();
            got_tx[21-i] = s_tx; got_done[21-i] = s_done;
            in_byte = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            if (i == 11) in_valid = 1'b0;
        end
        tests_run++;
        if (got_tx !== {11'b01111000011, 11'b00000111111}) begin
            tests_failed++;
            $display("FAIL stall_stream: got %b expected 0111100001100000111111", got_tx);
        end
        tests_run++;
        if (got_done !== 22'b0000000000100000000001) begin
            tests_failed++;
            $display("FAIL stall_done_count: got %b expected 0000000000100000000001", got_done);
        end
        step(); step();
        tests_run++;
        if ({s_tx, s_busy, s_done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL stall_no_extra_frame: got tx/busy/done=%b expected 100", {s_tx, s_busy, s_done});
        end
        $display("[TB] stalled frames 0x0f,0xf0 tx=%b", got_tx);
    endtask

    task automatic test_reset_mid();
        logic [5:0]  got_head;
        logic [10:0] got_tx, got_done;
        in_valid = 1'b1; in_byte = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            step();
            got_head[5-i] = s_tx;
            if (i == 0) in_valid = 1'b0;
        end
        tests_run++;
        if (got_head !== 6'b001011) begin
            tests_failed++;
            $display("FAIL midreset_head: got %b expected 001011", got_head);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if ({s_tx, s_busy, s_done, s_ready} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL midreset_during: got tx/busy/done/ready=%b expected 1000", {s_tx, s_busy, s_done, s_ready});
        end
        reset = 1'b0;
        step();
        tests_run++;
        if ({s_tx, s_busy, s_done, s_ready} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL midreset_after: got tx/busy/done/ready=%b expected 1001", {s_tx, s_busy, s_done, s_ready});
        end
        in_valid = 1'b1; in_byte = 8'h3C;
        for (int i = 0; i < 11; i++) begin
            step();
            got_tx[10-i] = s_tx; got_done[10-i] = s_done;
            if (i == 0) in_valid = 1'b0;
        end
        tests_run++;
        if (got_tx !== 11'b00011110011 || got_done !== 11'b00000000001) begin
            tests_failed++;
            $display("FAIL midreset_next_frame: got tx=%b done=%b expected 00011110011/00000000001", got_tx, got_done);
        end
        step();
        $display("[TB] reset mid-frame then 0x3c tx=%b", got_tx);
    endtask

    task automatic test_gap_loopback();
        logic [7:0] vals [3] = '{8'h12, 8'h34, 8'h56};
        logic       stream [50];
        logic       rdy [50];
        logic       dn [50];
        logic [7:0] rx_bytes [3];
        logic [7:0] data;
        int         idx, n_done, n_rx, i;
        logic       xfer;
        idx = 0; n_done = 0; n_rx = 0;
        tests_run++;
        if (sg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_idle_ready: got %b expected 1", sg_ready);
        end
        g_in_valid = 1'b1; g_in_byte = vals[0];
        for (int c = 0; c < 50; c++) begin
            xfer = sg_ready && g_in_valid;
            step();
            stream[c] = sg_tx; rdy[c] = sg_ready; dn[c] = sg_done;
            if (xfer) begin
                idx++;
                if (idx < 3) g_in_byte = vals[idx];
                else g_in_valid = 1'b0;
            end
        end
        for (int c = 0; c < 47; c++) begin
            if (dn[c]) begin
                tests_run++;
                if (c !== 10 + 13 * n_done) begin
                    tests_failed++;
                    $display("FAIL gap_done_position: got cycle %0d expected %0d", c, 10 + 13 * n_done);
                end
                tests_run++;
                if ({stream[c+1], stream[c+2], rdy[c+1], rdy[c+2]} !== 4'b1101) begin
                    tests_failed++;
                    $display("FAIL gap_cycles: got tx/tx/ready/ready=%b expected 1101", {stream[c+1], stream[c+2], rdy[c+1], rdy[c+2]});
                end
                n_done++;
            end
        end
        // Behavioural receiver: hunt for a start bit, then take a fixed 11-bit frame.
        i = 0;
        while (i + 10 < 50) begin
            if (stream[i] == 1'b0) begin
                for (int b = 0; b < 8; b++) data[b] = stream[i+1+b];
                tests_run++;
                if ({(^data) ^ stream[i+9], stream[i+10]} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL rx_frame_check: got parity_ok/stop=%b expected 11", {(^data) ^ stream[i+9], stream[i+10]});
                end
                if (n_rx < 3) rx_bytes[n_rx] = data;
                n_rx++;
                $display("[TB] rx done out_byte=0x%h", data);
                i += 11;
            end else begin
                i++;
            end
        end
        tests_run++;
        if (n_rx !== 3 || n_done !== 3) begin
            tests_failed++;
            $display("FAIL rx_count: got frames=%0d done=%0d expected 3/3", n_rx, n_done);
        end
        for (int k = 0; k < 3 && k < n_rx; k++) begin
            tests_run++;
            if (rx_bytes[k] !== vals[k]) begin
                tests_failed++;
                $display("FAIL rx_byte_%0d: got %h expected %h", k, rx_bytes[k], vals[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_stall();
        test_reset_mid();
        test_gap_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
